// File: rtl/mux4_serializer.sv
// Serializes a 4-bit word onto a 2-bit mux select and a reference bit stream,
// holding each select value for HOLD cycles and pulsing done after the last bit.
module mux4_serializer #(
  parameter int HOLD = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  output logic [1:0] sel,
  output logic       ser_out,
  output logic       ser_valid,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

  state_t     state, state_nxt;
  logic [3:0] data_buf, buf_nxt;
  logic [1:0] sel_nxt;
  logic [7:0] hold_cnt, hold_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      data_buf <= '0;
      sel      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      data_buf <= buf_nxt;
      sel      <= sel_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // sel stops at 3; the frame ends by moving to DONE rather than wrapping.
  always_comb begin
    state_nxt = state;
    buf_nxt   = data_buf;
    sel_nxt   = sel;
    hold_nxt  = hold_cnt;
    case (state)
      IDLE: begin
        if (in_valid) begin
          buf_nxt   = in_data;
          sel_nxt   = 2'd0;
          hold_nxt  = 8'd0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (hold_cnt != HOLD_LAST) begin
          hold_nxt = hold_cnt + 8'd1;
        end else begin
          hold_nxt = 8'd0;
          if (sel != 2'd3) begin
            sel_nxt = sel + 2'd1;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        sel_nxt   = 2'd0;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign ser_valid = (state == SHIFT);
  assign done      = (state == DONE);
  assign ser_out   = (state == SHIFT) ? data_buf[sel] : 1'b0;

endmodule

// File: tb/tb_mux4_serializer.sv
// Bench for mux4_serializer: two instances (HOLD=1 and HOLD=3) on a shared input
// bus, compared every cycle against a frame-position reference model.
module tb_mux4_serializer;

  typedef struct packed {
    logic       rdy;
    logic [1:0] sel;
    logic       so;
    logic       sv;
    logic       dn;
  } out_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'd0;

  logic       rdy1, so1, sv1, dn1;
  logic [1:0] sel1;
  logic       rdy3, so3, sv3, dn3;
  logic [1:0] sel3;
  out_t       o1, o3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux4_serializer #(.HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy1), .sel(sel1), .ser_out(so1), .ser_valid(sv1), .done(dn1)
  );

  mux4_serializer #(.HOLD(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy3), .sel(sel3), .ser_out(so3), .ser_valid(sv3), .done(dn3)
  );

  assign o1 = {rdy1, sel1, so1, sv1, dn1};
  assign o3 = {rdy3, sel3, so3, sv3, dn3};

  function automatic out_t get_obs(input int h);
    return (h == 1) ? o1 : o3;
  endfunction

  // Expected outputs i cycles after the accepting edge; i=0 or beyond the frame is idle.
  function automatic out_t model(input logic [3:0] w, input int h, input int i);
    out_t r;
    r.rdy = 1'b1;
    r.sel = 2'd0;
    r.so  = 1'b0;
    r.sv  = 1'b0;
    r.dn  = 1'b0;
    if (i >= 1 && i <= 4 * h) begin
      r.rdy = 1'b0;
      r.sv  = 1'b1;
      r.sel = 2'((i - 1) / h);
      r.so  = w[r.sel];
    end else if (i == 4 * h + 1) begin
      r.rdy = 1'b0;
      r.dn  = 1'b1;
      r.sel = 2'd3;
    end
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    out_t idle;
    idle = model(4'd0, 1, 0);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 4'b1111;
    repeat (2) @(negedge clk);
    checks++;
    if (o1 !== idle) begin
      failures++;
      $display("[TB] FAIL reset_h1 got=%b exp=%b", o1, idle);
    end
    checks++;
    if (o3 !== idle) begin
      failures++;
      $display("[TB] FAIL reset_h3 got=%b exp=%b", o3, idle);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (o1 !== idle || o3 !== idle) begin
        failures++;
        $display("[TB] FAIL idle cyc=%0d got1=%b got3=%b exp=%b", i, o1, o3, idle);
      end
    end
  endtask

  task automatic test_hold1();
    out_t e;
    do_reset();
    in_valid = 1'b1;
    in_data = 4'b0110;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) in_valid = 1'b0;
      e = model(4'b0110, 1, i);
      checks++;
      if (o1 !== e) begin
        failures++;
        $display("[TB] FAIL hold1 cyc=%0d got=%b exp=%b", i, o1, e);
      end
    end
  endtask

  task automatic test_hold3();
    out_t e;
    do_reset();
    in_valid = 1'b1;
    in_data = 4'b1011;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 1) in_valid = 1'b0;
      e = model(4'b1011, 3, i);
      checks++;
      if (o3 !== e) begin
        failures++;
        $display("[TB] FAIL hold3 cyc=%0d got=%b exp=%b", i, o3, e);
      end
    end
  endtask

  task automatic test_busy();
    out_t e;
    do_reset();
    in_valid = 1'b1;
    in_data = 4'b0001;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) in_data = 4'b1110;
      e = model(4'b0001, 1, i);
      checks++;
      if (o1 !== e) begin
        failures++;
        $display("[TB] FAIL busy_first cyc=%0d got=%b exp=%b", i, o1, e);
      end
    end
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) in_valid = 1'b0;
      e = model(4'b1110, 1, i);
      checks++;
      if (o1 !== e) begin
        failures++;
        $display("[TB] FAIL busy_second cyc=%0d got=%b exp=%b", i, o1, e);
      end
    end
  endtask

  task automatic test_midreset();
    out_t e;
    do_reset();
    in_valid = 1'b1;
    in_data = 4'b1111;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (i == 1) in_valid = 1'b0;
      e = model(4'b1111, 3, i);
      checks++;
      if (o3 !== e) begin
        failures++;
        $display("[TB] FAIL midreset_pre cyc=%0d got=%b exp=%b", i, o3, e);
      end
    end
    rst = 1'b1;
    e = model(4'd0, 3, 0);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (o3 !== e) begin
        failures++;
        $display("[TB] FAIL midreset_idle cyc=%0d got=%b exp=%b", i, o3, e);
      end
    end
    in_valid = 1'b1;
    in_data = 4'b1000;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 1) in_valid = 1'b0;
      e = model(4'b1000, 3, i);
      checks++;
      if (o3 !== e) begin
        failures++;
        $display("[TB] FAIL midreset_post cyc=%0d got=%b exp=%b", i, o3, e);
      end
    end
  endtask

  task automatic test_back_to_back(input int h);
    logic [3:0] words [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                              4'b1110, 4'b1101, 4'b1011, 4'b0110};
    out_t o, e;
    logic mux_out;
    int dones;
    dones = 0;
    do_reset();
    in_valid = 1'b1;
    in_data = words[0];
    for (int w = 0; w < 8; w++) begin
      for (int i = 1; i <= 4 * h + 2; i++) begin
        @(negedge clk);
        o = get_obs(h);
        e = model(words[w], h, i);
        checks++;
        if (o !== e) begin
          failures++;
          $display("[TB] FAIL b2b_h%0d word=%0d cyc=%0d got=%b exp=%b", h, w, i, o, e);
        end
        // Downstream mux is fed the same word and steered by sel.
        if (o.sv === 1'b1) begin
          mux_out = in_data[o.sel];
          checks++;
          if (mux_out !== o.so) begin
            failures++;
            $display("[TB] FAIL b2b_mux_h%0d word=%0d cyc=%0d got=%b exp=%b", h, w, i, o.so, mux_out);
          end
        end
        if (o.dn === 1'b1) dones++;
        if (i == 4 * h + 2) begin
          if (w == 7) in_valid = 1'b0;
          else in_data = words[w + 1];
        end
      end
    end
    checks++;
    if (dones != 8) begin
      failures++;
      $display("[TB] FAIL b2b_done_count_h%0d got=%0d exp=8", h, dones);
    end
  endtask

  task automatic test_random(input int h);
    out_t o, e;
    logic [3:0] word;
    int gap;
    do_reset();
    for (int f = 0; f < 12; f++) begin
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        in_data = 4'($urandom);
        @(negedge clk);
        o = get_obs(h);
        e = model(4'd0, h, 0);
        checks++;
        if (o !== e) begin
          failures++;
          $display("[TB] FAIL rand_gap_h%0d frame=%0d got=%b exp=%b", h, f, o, e);
        end
      end
      word = 4'($urandom);
      in_valid = 1'b1;
      in_data = word;
      // Random valid/data noise while busy, including the done cycle, must be ignored.
      for (int i = 1; i <= 4 * h + 2; i++) begin
        @(negedge clk);
        o = get_obs(h);
        e = model(word, h, i);
        checks++;
        if (o !== e) begin
          failures++;
          $display("[TB] FAIL rand_h%0d frame=%0d cyc=%0d got=%b exp=%b", h, f, i, o, e);
        end
        if (i <= 4 * h + 1) begin
          in_valid = 1'($urandom_range(0, 1));
          in_data = 4'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_hold1();
    test_hold3();
    test_busy();
    test_midreset();
    test_back_to_back(1);
    test_back_to_back(3);
    test_random(1);
    test_random(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux4_serializer.md
Name: mux4_serializer

Overview:
- Upstream driver for the 4-to-1 mux stage. Accepts a 4-bit word over a valid/ready handshake and steps the 2-bit select through channels 0..3.
- Presents each selected bit as a serial output, holding each bit for a programmable number of cycles, then pulses done.
- The sel output wires directly to the downstream mux select. ser_out is the reference value the mux output must match.

Parameters:
- HOLD, 1, cycles each bit/select value is held; legal range 1..255; internal hold counter is 8 bits.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream word valid.
- in_data  input  4  word to serialize; bit i is emitted when sel==i.
- in_ready  output  1  block can accept a word.
- sel  output  2  select value driven to the downstream mux.
- ser_out  output  1  currently selected bit, buf[sel].
- ser_valid  output  1  sel/ser_out carry a live bit.
- done  output  1  one-cycle pulse after the last bit.

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-high (rst), sampled on the rising edge of clk and dominant over all other inputs.
- State machine: IDLE, SHIFT, DONE, plus a 4-bit buffer buf, 2-bit sel register and 8-bit hold_cnt.
- Reset values: state=IDLE, buf=0, sel=0, hold_cnt=0, ser_out=0, ser_valid=0, done=0. in_ready=1 from the first cycle after reset.
- Output decode (combinational from registered state):
  - in_ready = (state==IDLE).
  - ser_valid = (state==SHIFT).
  - done = (state==DONE).
  - ser_out = buf[sel] in SHIFT, else 0.
- IDLE:
  - Transfer occurs when in_valid && in_ready at a rising edge.
  - On transfer: buf<=in_data, sel<=0, hold_cnt<=0, state<=SHIFT.
  - in_data is ignored when in_valid=0.
- SHIFT:
  - While hold_cnt<HOLD-1: hold_cnt increments; sel and buf are unchanged.
  - When hold_cnt==HOLD-1 and sel<3: sel<=sel+1, hold_cnt<=0.
  - When hold_cnt==HOLD-1 and sel==3: state<=DONE, hold_cnt<=0.
  - sel never wraps 3->0 inside SHIFT.
- DONE: lasts exactly one cycle. sel<=0, state<=IDLE.
- Latency, for a word accepted at edge k:
  - ser_valid is high for cycles k+1 .. k+4*HOLD.
  - done is high in cycle k+4*HOLD+1.
  - in_ready returns high in cycle k+4*HOLD+2.
  - Minimum word-to-word spacing is 4*HOLD+2 cycles.
- Busy behaviour:
  - in_valid during SHIFT/DONE is not captured and has no effect.
  - Upstream must hold in_valid/in_data until in_ready.
  - A change on in_data mid-frame does not affect buf.
- Simultaneous events: rst together with in_valid means reset wins and no capture occurs. In_valid high in the DONE cycle is not accepted; it is accepted in the following IDLE cycle.
- Reset mid-frame: the next cycle is IDLE with all outputs at reset values. The partial frame is discarded and no done pulse is produced.
- HOLD=1 means sel advances every cycle.
- Downstream check: with the mux fed the same in_data, the mux output equals ser_out in every ser_valid cycle.

Test Plan:
- Reset then idle: rst high 2 cycles -> sel=0, ser_out=0, ser_valid=0, done=0, in_ready=1; no change over 5 idle cycles.
- HOLD=1, in_data=4'b0110 accepted at edge k:
  - sel=0,1,2,3 and ser_out=0,1,1,0 in cycles k+1..k+4.
  - done=1 at k+5.
  - in_ready=1 at k+6.
- HOLD=3, in_data=4'b1011: each sel value is held 3 cycles, with ser_out=1,1,0,1. ser_valid is high 12 cycles, done at k+13.
- Busy rejection: accept 4'b0001, then drive in_valid=1 with in_data=4'b1110 throughout the frame:
  - The first frame outputs 1,0,0,0.
  - 4'b1110 is accepted at the first IDLE edge after done and outputs 0,1,1,1.
- Reset mid-frame: accept 4'b1111, assert rst while sel=2 -> next cycle IDLE, ser_valid=0, sel=0, no done pulse. A subsequent 4'b1000 frame outputs 0,0,0,1.
- Back-to-back with the mux attached: words 0001, 0010, 0100, 1000, 1110, 1101, 1011, 0110, each issued the moment in_ready rises -> mux output equals ser_out every ser_valid cycle, with 8 done pulses total.
